// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants for the CPU data memory.
//   DM_DEFAULT_DEPTH : default storage size in bytes
//   DW_BYTES         : bytes per doubleword access beat
//   PRELOAD_BASE/N   : doubleword window filled by the reset-time sort workload
//   PRELOAD_VALS     : the ten unsigned 64-bit workload values
package data_mem_pkg;

    localparam int unsigned DM_DEFAULT_DEPTH = 256;
    localparam int unsigned DW_BYTES         = 8;
    localparam int unsigned PRELOAD_BASE     = 1;
    localparam int unsigned PRELOAD_N        = 10;

    localparam logic [63:0] PRELOAD_VALS [PRELOAD_N] = '{
        64'd5, 64'd3, 64'd9, 64'd1, 64'd7,
        64'd10, 64'd2, 64'd8, 64'd4, 64'd6
    };

endpackage

// File: rtl/data_mem.sv
// data_mem: byte-addressed 64-bit data memory for the CPU load/store port.
//   clk      : single clock, all updates on rising edge
//   rst      : synchronous active-high reset (clears, optionally preloads)
//   mem_data : shared 64-bit bus; driven here for loads, high-Z for stores
//   mem_rw   : 1 = store, 0 = load
//   addr     : byte address, only the low log2(DEPTH_BYTES) bits are used
// Accesses are 64-bit little-endian, unaligned allowed, wrapping per byte.
// DM is the byte storage; comb_DM is its combinational doubleword view.
// Build option: define DATA_MEM_PRELOAD_EN to load the sort workload into
// doublewords 1..10 on reset; otherwise reset only clears memory.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DM_DEFAULT_DEPTH,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [63:0]       mem_data,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] addr
);

    localparam int unsigned AW     = $clog2(DEPTH_BYTES);
    localparam int unsigned N_DW   = DEPTH_BYTES / DW_BYTES;

    logic [7:0]    DM      [DEPTH_BYTES];
    logic [63:0]   comb_DM [N_DW];

    logic [AW-1:0] a_c;
    logic [63:0]   rd_data_c;
    logic          unused_addr_c;

    // Upper address bits are intentionally ignored; the address wraps.
    assign a_c           = addr[AW-1:0];
    assign unused_addr_c = ^addr;

    // Doubleword view of the byte store, little-endian.
    always_comb begin
        for (int k = 0; k < int'(N_DW); k++) begin
            comb_DM[k] = '0;
            for (int b = 0; b < int'(DW_BYTES); b++) begin
                comb_DM[k][8*b +: 8] = DM[AW'(k * int'(DW_BYTES) + b)];
            end
        end
    end

    // Load beat: 8 bytes starting at a_c, each index wrapping mod depth.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(DW_BYTES); i++) begin
            rd_data_c[8*i +: 8] = DM[a_c + AW'(i)];
        end
    end

    // Never drive the bus while the CPU is storing.
    assign mem_data = (~mem_rw) ? rd_data_c : {64{1'bz}};

    // Storage update: reset image has priority over a same-cycle store.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
                DM[AW'(i)] <= 8'h00;
            end
`ifdef DATA_MEM_PRELOAD_EN
            // Later assignments override the clear above for the workload window.
            for (int k = 0; k < int'(PRELOAD_N); k++) begin
                for (int b = 0; b < int'(DW_BYTES); b++) begin
                    DM[AW'((int'(PRELOAD_BASE) + k) * int'(DW_BYTES) + b)] <=
                        PRELOAD_VALS[k][8*b +: 8];
                end
            end
`endif
        end else if (mem_rw) begin
            for (int i = 0; i < int'(DW_BYTES); i++) begin
                DM[a_c + AW'(i)] <= mem_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed plus randomized checks of data_mem against a
// byte-array reference model held in the bench.
module tb_data_mem;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned NDW   = DEPTH / 8;

    logic        clk;
    logic        rst;
    logic        mem_rw;
    logic [63:0] addr;
    logic        drv_en;
    logic [63:0] wdata;
    wire  [63:0] mem_data;

    int nvec;
    int nerr;

    logic [7:0]  mdl [DEPTH];
    logic [63:0] pre [10];

    assign mem_data = drv_en ? wdata : {64{1'bz}};

    data_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_data (mem_data),
        .mem_rw   (mem_rw),
        .addr     (addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(input logic [63:0] ad);
        return int'(ad % 64'(DEPTH));
    endfunction

    function automatic logic [63:0] mdl_rd(input logic [63:0] ad);
        logic [63:0] v;
        int a;
        a = eff(ad);
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mdl[(a + i) % int'(DEPTH)];
        return v;
    endfunction

    task automatic mdl_wr(input logic [63:0] ad, input logic [63:0] v);
        int a;
        a = eff(ad);
        for (int i = 0; i < 8; i++) mdl[(a + i) % int'(DEPTH)] = v[8*i +: 8];
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 8'h00;
`ifdef DATA_MEM_PRELOAD_EN
        for (int k = 0; k < 10; k++) mdl_wr(64'((k + 1) * 8), pre[k]);
`endif
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs at one rising edge, updating the model alike.
    task automatic tick();
        if (rst) mdl_reset();
        else if (mem_rw) mdl_wr(addr, wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] ad, input logic [63:0] v);
        addr = ad; wdata = v; mem_rw = 1'b1; drv_en = 1'b1;
        tick();
        mem_rw = 1'b0; drv_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [63:0] ad);
        addr = ad; mem_rw = 1'b0; drv_en = 1'b0;
        #1;
        chk(tag, mem_data, mdl_rd(ad));
    endtask

    task automatic chk_dw(input string tag, input int k);
        chk(tag, dut.comb_DM[k], mdl_rd(64'(k * 8)));
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [7:0] exp);
        chk(tag, 64'(dut.DM[i]), 64'(exp));
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rv;
        int          k;

        nvec = 0;
        nerr = 0;
        pre = '{64'd5, 64'd3, 64'd9, 64'd1, 64'd7, 64'd10, 64'd2, 64'd8, 64'd4, 64'd6};
        rst = 1'b1; mem_rw = 1'b1; drv_en = 1'b0; addr = 64'd0; wdata = 64'd0;

        // Store cycle with nobody driving: bus must float. Reset blocks the store.
        #2;
        nvec++;
        assert (mem_data === {64{1'bz}}) else begin
            nerr++;
            $error("FAIL tristate: observed %h expected all Z", mem_data);
        end
        tick();

        // Reset image and first load.
        rst = 1'b0;
        do_read("rst_rd8", 64'd8);
`ifdef DATA_MEM_PRELOAD_EN
        chk("rst_rd8_const", mem_data, 64'd5);
`else
        chk("rst_rd8_const", mem_data, 64'd0);
`endif
        nvec++;
        assert (!$isunknown(mem_data)) else begin
            nerr++;
            $error("FAIL drive_defined: observed %h expected no X/Z", mem_data);
        end
        for (int j = 0; j <= 20; j++) chk_dw("rst_image", j);

        // Aligned store then load.
        do_write(64'd88, 64'h1122334455667788);
        do_read("aligned_rd", 64'd88);
        chk("aligned_dw11", dut.comb_DM[11], 64'h1122334455667788);
        chk_byte("aligned_b88", 88, 8'h88);
        chk_byte("aligned_b95", 95, 8'h11);

        // Reset wins over a same-cycle store.
        rst = 1'b1; addr = 64'd16; wdata = 64'd99; mem_rw = 1'b1; drv_en = 1'b1;
        tick();
        rst = 1'b0; mem_rw = 1'b0; drv_en = 1'b0;
        chk_dw("rst_prio_dw2", 2);
        chk_dw("rst_prio_dw11", 11);

        // Unaligned store wrapping past the top of memory.
        do_write(64'(DEPTH - 4), 64'hAABBCCDDEEFF0011);
        chk_byte("wrap_b252", int'(DEPTH) - 4, 8'h11);
        chk_byte("wrap_b253", int'(DEPTH) - 3, 8'h00);
        chk_byte("wrap_b254", int'(DEPTH) - 2, 8'hFF);
        chk_byte("wrap_b255", int'(DEPTH) - 1, 8'hEE);
        chk_byte("wrap_b0", 0, 8'hDD);
        chk_byte("wrap_b1", 1, 8'hCC);
        chk_byte("wrap_b2", 2, 8'hBB);
        chk_byte("wrap_b3", 3, 8'hAA);
        do_read("wrap_rd_alias", 64'(2 * DEPTH - 4));
        chk("wrap_rd_const", mem_data, 64'hAABBCCDDEEFF0011);
        do_read("wrap_rd_hi", 64'hFFFF_0000_0000_0000 | 64'(DEPTH - 4));

        // Randomized loads, stores and occasional resets.
        for (int n = 0; n < 300; n++) begin
            ra = {$urandom(), $urandom()};
            rv = {$urandom(), $urandom()};
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; mem_rw = 1'($urandom_range(0, 1)); drv_en = mem_rw;
                addr = ra; wdata = rv;
                tick();
                rst = 1'b0; mem_rw = 1'b0; drv_en = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                do_write(ra, rv);
            end else begin
                do_read("rand_rd", ra);
            end
            k = int'($urandom_range(0, NDW - 1));
            chk_dw("rand_dw", k);
        end

        // Sort-result style check: ascending values in dwords 11..20.
        rst = 1'b1; mem_rw = 1'b0;
        tick();
        rst = 1'b0;
        for (int j = 1; j <= 10; j++) do_write(64'((10 + j) * 8), 64'(j));
        for (int j = 11; j < 20; j++)
            chk("sort_order", 64'(dut.comb_DM[j] <= dut.comb_DM[j + 1]), 64'd1);
        for (int j = 1; j <= 20; j++) chk_dw("sort_dw", j);
        do_read("sort_rd_last", 64'd160);
        chk("sort_rd_last_const", mem_data, 64'd10);

        for (int j = 0; j < int'(NDW); j++) chk_dw("final_dw", j);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
